// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Operation codes and control-state type shared by the ALU
//               execution unit and its iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_iter_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_mul
// Description : Shift-add multiplier, one bit of b per cycle over WIDTH cycles;
//               product holds the low WIDTH bits of a*b in the done cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int             c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  logic             r_busy;
  logic [c_cw-1:0]  r_count;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_partial;
  logic [WIDTH-1:0] w_sum;

  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign w_sum     = r_acc + w_partial;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (r_count == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  // The last bit's partial sum is presented combinationally so the caller
  // can register the full product on the same edge that ends the run.
  assign busy    = r_busy;
  assign done    = r_busy && (r_count == c_last);
  assign product = w_sum;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Registered ALU stage with valid/ready handshake and flush.
//               Define ALU_EXEC_MUL_EN to add the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  alu_state_t       r_state;
  alu_state_t       w_state_next;
  alu_state_t       w_start_state;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_alu_load;
  logic             w_mul_load;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] r_result;

  assign w_accept = in_valid && w_in_ready;

`ifdef ALU_EXEC_MUL_EN
  logic w_is_mul;
  logic w_mul_busy;
  logic w_mul_done;
  logic w_mul_clr;

  assign w_is_mul      = (operation == OP_MUL);
  assign w_start_state = w_is_mul ? BUSY : DONE;
  assign w_alu_load    = w_accept && !w_is_mul;
  assign w_mul_clr     = reset || flush;
  assign w_mul_load    = (r_state == BUSY) && w_mul_done && !flush;

  alu_iter_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (w_mul_clr),
    .start   (w_accept && w_is_mul),
    .a       (op_a),
    .b       (op_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );
`else
  assign w_start_state = DONE;
  assign w_alu_load    = w_accept;
  assign w_mul_load    = 1'b0;
  assign w_mul_product = '0;
`endif

  always_comb begin
    case (operation)
      OP_AND:  w_alu = op_a & op_b;
      OP_OR:   w_alu = op_a | op_b;
      OP_ADD:  w_alu = op_a + op_b;
      default: w_alu = op_a - op_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) w_state_next = w_start_state;
        end
`ifdef ALU_EXEC_MUL_EN
        BUSY: begin
          // Losing busy without done means the multiplier was cleared; recover.
          if (w_mul_done)       w_state_next = DONE;
          else if (!w_mul_busy) w_state_next = IDLE;
        end
`endif
        DONE: begin
          if (out_ready) w_state_next = w_accept ? w_start_state : IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready = 1'b0;
    out_valid  = 1'b0;
    if (!reset && !flush) begin
      w_in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    end
    if (r_state == DONE) begin
      out_valid = 1'b1;
    end
  end

  assign in_ready = w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else if (w_alu_load) begin
      r_result <= w_alu;
    end else if (w_mul_load) begin
      r_result <= w_mul_product;
    end
  end

  assign result = r_result;
  assign zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, operands and operation present.
- in_ready, out, 1, unit can accept this cycle.
- operation, in, 4, ALU control code.
- op_a, in, WIDTH, source A.
- op_b, in, WIDTH, source B.
- flush, in, 1, pipeline flush; abort work and drop the result.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- result, out, WIDTH, registered result.
- zero, out, 1, result == 0, for branch resolve.

Function
REQ-004 SHALL define accept as in_valid && in_ready at a rising edge, and output transfer as out_valid && out_ready.
REQ-005 SHALL decode operation as: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B), 1000 MUL (see Configuration); every other code SHALL execute as SUB.
REQ-006 SHALL perform ADD/SUB modulo 2^WIDTH, discarding carry and borrow.
REQ-007 SHALL use states IDLE, BUSY and DONE.
REQ-008 SHALL, for a single-cycle op accepted in IDLE at edge N, go to DONE with result/zero registered and out_valid=1 after edge N.
REQ-009 SHALL drive in_ready=1 only when state is IDLE, or state is DONE and out_ready=1, and flush=0.
REQ-010 SHALL support back-to-back operation: in DONE with out_ready=1 and a new single-cycle accept, present the new result on the next cycle with no bubble.
REQ-011 SHALL, in DONE with out_ready=0, hold result, zero and out_valid stable.
REQ-012 SHALL, in DONE with out_ready=1 and no new accept, return to IDLE and set out_valid=0.
REQ-013 SHALL compute zero from the registered result only, valid whenever out_valid=1.
REQ-014 SHALL, on flush=1, go to IDLE at the next edge with out_valid=0 and any BUSY work discarded; flush SHALL take priority over accept and completion in the same cycle.
REQ-015 SHALL hold in_ready=0 and out_valid=0 throughout BUSY.

Reset
REQ-016 SHALL, on reset, force state=IDLE, out_valid=0, result=0, zero=1, and clear the multiplier counter and accumulators, regardless of state, including mid-MUL.
REQ-017 SHALL give reset priority over flush and accept.
REQ-018 SHALL drive in_ready=0 during the reset cycle and in_ready=1 on the first cycle after reset.

Configuration
REQ-019 SHALL include an iterative multiplier when macro ALU_EXEC_MUL_EN is defined.
- Code 1000 SHALL enter BUSY.
- It SHALL perform shift-add, one bit of op_b per cycle, for WIDTH cycles.
- It SHALL then enter DONE with the low WIDTH bits of A*B.
- A MUL accepted at edge N SHALL give out_valid=1 after edge N+WIDTH.
REQ-020 SHALL, without ALU_EXEC_MUL_EN, contain no BUSY logic and no multiplier; code 1000 SHALL execute as single-cycle SUB.

Structure
REQ-021 SHALL take the following from shared package alu_pkg:
- the operation code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL);
- the state enum typedef alu_state_t.
REQ-022 SHALL place the multiplier in sub-module alu_iter_mul, with ports start, a, b, busy, done and product, instantiated only under ALU_EXEC_MUL_EN; the control FSM stays in alu_exec_unit.

Verification
REQ-023 SHALL pass: ADD 5, 7 accepted -> next cycle out_valid=1, result=12, zero=0.
REQ-024 SHALL pass: SUB 9, 9 -> result=0, zero=1; code 1111 with 3, 1 -> result=2 (SUB default).
REQ-025 SHALL pass: with out_ready=0 for 4 cycles after AND 0xF0F0, 0xFF00 -> result=0xF000 held stable and in_ready=0; out_ready=1 -> transfer, and in_ready=1 the same cycle.
REQ-026 SHALL pass, with ALU_EXEC_MUL_EN and WIDTH=32: MUL 6, 7 -> in_ready=0 for 32 cycles, then result=42; MUL 0xFFFFFFFF, 2 -> 0xFFFFFFFE.
REQ-027 SHALL pass: flush at cycle 10 of a MUL -> IDLE next edge, out_valid never asserts, and the next ADD 1, 1 gives 2.
REQ-028 SHALL pass: reset asserted mid-MUL and while in DONE -> out_valid=0, result=0, zero=1 the next cycle, and in_ready=1 after reset drops.
